test_pattern_driver: RTL and testbench

TEST_PATTERN_DRIVER -- requirements
Module: test_pattern_driver

---
 rtl/test_pattern_driver.sv | 133 +++++++++++++
 tb/tb_test_pattern_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_driver.sv
// Drives a 13-input circuit under test with an LFSR pattern sequence and
// folds the serial response bit into a 16-bit MISR and a ones counter.
module test_pattern_driver #(
  parameter int          SETTLE   = 1,
  parameter logic [15:0] SIG_INIT = 16'h0000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        start,
  input  logic [12:0] seed,
  input  logic [15:0] pattern_count,
  input  logic        dut_resp,
  output logic        dut_clr,
  output logic [12:0] vec,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [15:0] ones_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t      r_state;
  logic [12:0] r_vec;
  logic [15:0] r_remain;
  logic [3:0]  r_settle;
  logic [15:0] r_sig;
  logic [15:0] r_ones;
  logic        r_busy;
  logic        r_done;
  logic        r_dut_clr;

  logic [12:0] w_vec_next;
  logic [15:0] w_sig_next;
  logic [15:0] w_ones_next;

  // x^13 + x^4 + x^3 + x + 1, shifting toward the MSB
  function automatic logic [12:0] lfsr_next(input logic [12:0] v);
    return {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic b);
    return (b && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

  assign w_vec_next  = lfsr_next(r_vec);
  assign w_sig_next  = misr_next(r_sig, dut_resp);
  assign w_ones_next = sat_inc(r_ones, dut_resp);

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_state   <= S_IDLE;
      r_vec     <= '0;
      r_remain  <= '0;
      r_settle  <= '0;
      r_sig     <= SIG_INIT;
      r_ones    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dut_clr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= S_LOAD;
            r_vec     <= (seed == 13'h0000) ? 13'h0001 : seed;
            r_remain  <= pattern_count;
            r_sig     <= SIG_INIT;
            r_ones    <= '0;
            r_busy    <= 1'b1;
            r_dut_clr <= 1'b0;
          end
        end
        S_LOAD: begin
          if (r_remain == 16'd0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_APPLY;
            r_dut_clr <= 1'b1;
            r_settle  <= SETTLE_M1;
          end
        end
        S_APPLY: begin
          if (r_settle == 4'd0) r_state <= S_CAPTURE;
          else                  r_settle <= r_settle - 4'd1;
        end
        S_CAPTURE: begin
          r_sig    <= w_sig_next;
          r_ones   <= w_ones_next;
          r_remain <= r_remain - 16'd1;
          // Last pattern keeps its vector so it stays visible after the run
          if (r_remain == 16'd1) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state  <= S_APPLY;
            r_vec    <= w_vec_next;
            r_settle <= SETTLE_M1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_clr    = r_dut_clr;
  assign vec        = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign signature  = r_sig;
  assign ones_count = r_ones;

endmodule

// File: tb/tb_test_pattern_driver.sv
// Randomized bench for test_pattern_driver: a run-level timing model plus
// LFSR/MISR reference arithmetic predicts every output cycle by cycle.
module tb_test_pattern_driver;

  localparam int          S_T   = 3;
  localparam logic [15:0] SIG_I = 16'h0000;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        start;
  logic [12:0] seed;
  logic [15:0] pattern_count;
  logic        dut_resp;
  logic        dut_clr;
  logic [12:0] vec;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] ones_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_sig;
  logic [15:0] exp_ones;
  logic [12:0] exp_vec;
  logic [12:0] cap_vec [16];

  test_pattern_driver #(.SETTLE(S_T), .SIG_INIT(SIG_I)) u_dut (
    .CLK(CLK), .CLR(CLR), .start(start), .seed(seed),
    .pattern_count(pattern_count), .dut_resp(dut_resp), .dut_clr(dut_clr),
    .vec(vec), .busy(busy), .done(done), .signature(signature),
    .ones_count(ones_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ref_lfsr(input logic [12:0] v);
    return {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
  endfunction

  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec"},  vec, 13'h0000);
    chk({tag, "_clr"},  dut_clr, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_sig"},  signature, SIG_I);
    chk({tag, "_ones"}, ones_count, 16'h0000);
  endtask

  // Entered and left just after a rising edge with the DUT in IDLE.
  // mode: 0 resp=0, 1 resp=1, 2 random. abort_at: cycle index to pull CLR low.
  task automatic run(input logic [12:0] sd, input int n, input int mode,
                     input bit hold, input int abort_at);
    logic [12:0] v;
    logic [15:0] sig, ones;
    logic        r;
    int          k, total;
    start = 1'b1;
    seed = sd;
    pattern_count = 16'(n);
    @(negedge CLK);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_sig", signature, exp_sig);
    chk("idle_ones", ones_count, exp_ones);
    chk("idle_vec", vec, exp_vec);
    @(posedge CLK); #1;
    if (!hold) start = 1'b0;
    seed = 13'($urandom);
    pattern_count = 16'($urandom);
    v = (sd == 13'h0000) ? 13'h0001 : sd;
    sig = SIG_I;
    ones = 16'h0000;
    k = 0;
    total = n * (S_T + 1) + 1;
    for (int c = 0; c <= total; c++) begin
      r = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      dut_resp = r;
      if (c == abort_at) CLR = 1'b0;
      @(negedge CLK);
      chk("run_busy", busy, (c < total) ? 1'b1 : 1'b0);
      chk("run_done", done, (c == total) ? 1'b1 : 1'b0);
      chk("run_vec", vec, v);
      chk("run_clr", dut_clr, (c == 0 || n == 0) ? 1'b0 : 1'b1);
      chk("run_sig", signature, sig);
      chk("run_ones", ones_count, ones);
      if (c > 0 && c < total && (c % (S_T + 1)) == 0) begin
        if (k < 16) cap_vec[k] = vec;
        sig = ref_misr(sig, r);
        if (r && ones != 16'hFFFF) ones = ones + 16'd1;
        k++;
        if (k < n) v = ref_lfsr(v);
      end
      @(posedge CLK); #1;
      if (c == abort_at) begin
        CLR = 1'b1;
        @(negedge CLK);
        chk_reset_vals("abort");
        exp_sig = SIG_I;
        exp_ones = 16'h0000;
        exp_vec = 13'h0000;
        @(posedge CLK); #1;
        return;
      end
    end
    exp_sig = sig;
    exp_ones = ones;
    exp_vec = v;
  endtask

  initial begin
    CLR = 1'b0;
    start = 1'b0;
    seed = 13'h0000;
    pattern_count = 16'h0000;
    dut_resp = 1'b0;
    exp_sig = SIG_I;
    exp_ones = 16'h0000;
    exp_vec = 13'h0000;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("reset");
    CLR = 1'b1;
    @(posedge CLK); #1;

    // Zero-length run: LOAD then DONE
    run(13'h0055, 0, 2, 1'b0, -1);
    chk("zero_sig", signature, 16'h0000);
    chk("zero_ones", ones_count, 16'h0000);

    // Zero seed replaced by 1, known LFSR sequence
    run(13'h0000, 4, 0, 1'b0, -1);
    chk("lfsr_v0", cap_vec[0], 13'h0001);
    chk("lfsr_v1", cap_vec[1], 13'h0003);
    chk("lfsr_v2", cap_vec[2], 13'h0007);
    chk("lfsr_v3", cap_vec[3], 13'h000E);
    chk("lfsr_sig", signature, 16'h0000);
    chk("lfsr_ones", ones_count, 16'h0000);

    // All-ones response, known MISR values
    run(13'h1234, 2, 1, 1'b0, -1);
    chk("misr_sig", signature, 16'h3063);
    chk("misr_ones", ones_count, 16'h0002);

    // Abort in APPLY of the second pattern, then a clean 5-pattern run
    run(13'h0A5A, 5, 2, 1'b0, S_T + 2);
    run(13'h1F0F, 5, 2, 1'b0, -1);

    // start held through a run: no restart while busy, restart after DONE
    run(13'h0777, 3, 2, 1'b1, -1);
    run(13'h0321, 2, 2, 1'b0, -1);

    for (int i = 0; i < 8; i++) begin
      run(13'($urandom), int'($urandom_range(0, 10)), 2, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
